boot_loader_ctrl: RTL and testbench

//  Boot sequencer ahead of clk_rst_mngr. Receives a program image as a byte stream (UART RX side)
//  and writes it word-by-word into instruction memory. Verifies a checksum, then raises
//  en_clk_div8 so the processor clock (clk_div8_proc) is released. Holds the core gated on error.

---
 rtl/boot_loader_ctrl.sv | 171 +++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: receives a program image as a byte stream and writes it
// word-by-word into instruction memory. Once the image checksum matches, the
// processor clock enable is raised and held until reset. Any error keeps the
// core gated.
// The image is a 16-bit big-endian word count N, then 4*N data bytes, then
// one checksum byte (sum of the data bytes, mod 256).
module boot_loader_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk_in,
  input  logic              rst_async_n,
  input  logic              boot_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              en_clk_div8,
  output logic              boot_busy,
  output logic              boot_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;
  localparam int          TW        = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]        r_rstSync;
  logic [2:0]        r_state;
  logic [7:0]        r_lenHi;
  logic [15:0]       r_wordsLeft;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_byteCnt;
  logic [23:0]       r_word;
  logic [7:0]        r_sum;
  logic [TW-1:0]     r_tmo;
  logic [ADDR_W-1:0] r_imemAddr;
  logic [31:0]       r_imemWdata;
  logic              r_imemWe;
  logic              r_enClk;

  logic              w_rstN;
  logic              w_rxState;
  logic              w_accept;
  logic              w_expire;
  logic [15:0]       w_hdrLen;

  assign w_rstN    = r_rstSync[1];
  assign w_rxState = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) ||
                     (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_accept  = rx_valid && w_rxState;
  assign w_expire  = (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_hdrLen  = {r_lenHi, rx_data};

  assign rx_ready    = w_rxState;
  assign boot_busy   = w_rxState || (r_state == S_WR);
  assign boot_err    = (r_state == S_ERR);
  assign imem_addr   = r_imemAddr;
  assign imem_wdata  = r_imemWdata;
  assign imem_we     = r_imemWe;
  assign en_clk_div8 = r_enClk;

  // Reset asserts immediately but is released only after two clean clk_in edges.
  always_ff @(posedge clk_in or negedge rst_async_n) begin
    if (!rst_async_n) r_rstSync <= 2'b00;
    else              r_rstSync <= {r_rstSync[0], 1'b1};
  end

  // Inactivity counter: counts cycles without an accepted byte while receiving.
  always_ff @(posedge clk_in or negedge w_rstN) begin
    if (!w_rstN)            r_tmo <= '0;
    else if (!w_rxState)    r_tmo <= '0;
    else if (w_accept)      r_tmo <= '0;
    else                    r_tmo <= r_tmo + TW'(1);
  end

  // Main sequencer: header decode, word assembly, memory writes and checksum.
  always_ff @(posedge clk_in or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state     <= S_IDLE;
      r_lenHi     <= '0;
      r_wordsLeft <= '0;
      r_idx       <= '0;
      r_byteCnt   <= '0;
      r_word      <= '0;
      r_sum       <= '0;
      r_imemAddr  <= '0;
      r_imemWdata <= '0;
      r_imemWe    <= 1'b0;
      r_enClk     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (boot_start) begin
            r_state   <= S_HDR_HI;
            r_idx     <= '0;
            r_sum     <= '0;
            r_byteCnt <= '0;
          end
        end
        S_HDR_HI: begin
          if (w_accept) begin
            r_lenHi <= rx_data;
            r_state <= S_HDR_LO;
          end else if (w_expire) begin
            r_state <= S_ERR;
          end
        end
        S_HDR_LO: begin
          if (w_accept) begin
            r_wordsLeft <= w_hdrLen;
            r_byteCnt   <= '0;
            if (w_hdrLen == 16'd0)                   r_state <= S_CSUM;
            else if ({16'd0, w_hdrLen} > MAX_WORDS)  r_state <= S_ERR;
            else                                     r_state <= S_DATA;
          end else if (w_expire) begin
            r_state <= S_ERR;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_word    <= {r_word[15:0], rx_data};
            r_sum     <= r_sum + rx_data;
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              r_imemAddr  <= r_idx;
              r_imemWdata <= {r_word, rx_data};
              r_imemWe    <= 1'b1;
              r_state     <= S_WR;
            end
          end else if (w_expire) begin
            r_state <= S_ERR;
          end
        end
        S_WR: begin
          r_imemWe    <= 1'b0;
          r_idx       <= r_idx + ADDR_W'(1);
          r_wordsLeft <= r_wordsLeft - 16'd1;
          if (r_wordsLeft == 16'd1) r_state <= S_CSUM;
          else                      r_state <= S_DATA;
        end
        S_CSUM: begin
          if (w_accept) begin
            if (rx_data == r_sum) begin
              r_state <= S_DONE;
              r_enClk <= 1'b1;
            end else begin
              r_state <= S_ERR;
            end
          end else if (w_expire) begin
            r_state <= S_ERR;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed testbench for boot_loader_ctrl. Uses a small memory (ADDR_W=4)
// and a short inactivity limit (TIMEOUT_CYC=100) so the range and timeout
// corner cases can be reached quickly.
// Status flag vectors below are ordered {rx_ready, imem_we, en_clk_div8, boot_busy, boot_err}.
module tb_boot_loader_ctrl;

  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 100;

  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_RX   = 5'b10010;
  localparam logic [4:0] F_WR   = 5'b01010;
  localparam logic [4:0] F_DONE = 5'b00100;
  localparam logic [4:0] F_ERR  = 5'b00001;

  logic              clk_in = 1'b0;
  logic              rst_async_n = 1'b0;
  logic              boot_start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_we;
  logic              en_clk_div8;
  logic              boot_busy;
  logic              boot_err;

  int checks = 0;
  int failures = 0;
  int writeCount = 0;
  int base = 0;
  logic [ADDR_W-1:0] wrAddr [0:63];
  logic [31:0]       wrData [0:63];
  logic [7:0]        img [0:63];
  logic [7:0]        sumExp;

  boot_loader_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_in      (clk_in),
    .rst_async_n (rst_async_n),
    .boot_start  (boot_start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .imem_we     (imem_we),
    .en_clk_div8 (en_clk_div8),
    .boot_busy   (boot_busy),
    .boot_err    (boot_err)
  );

  // Free-running system clock.
  always #5 clk_in = ~clk_in;

  // Log every memory write seen mid-cycle.
  always @(negedge clk_in) begin
    if (imem_we === 1'b1) begin
      wrAddr[writeCount % 64] = imem_addr;
      wrData[writeCount % 64] = imem_wdata;
      writeCount++;
    end
  end

  // Hard stop in case the stimulus itself gets stuck.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic [4:0] exp);
    checkOutput(tag, 32'({rx_ready, imem_we, en_clk_div8, boot_busy, boot_err}), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present one byte, waiting (bounded) until the block can take it.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCyc = 0;
    while (!rx_ready && waitCyc < 8) begin
      tick();
      waitCyc++;
    end
    if (!rx_ready) checkOutput("rx_ready_wait", 32'(rx_ready), 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulseStart();
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
  endtask

  task automatic applyReset();
    rst_async_n = 1'b0;
    tick();
    tick();
    rst_async_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic sendHeader(input logic [15:0] n);
    applyStimulus(n[15:8]);
    applyStimulus(n[7:0]);
  endtask

  task automatic sendData(input int first, input int last);
    for (int k = first; k <= last; k++) applyStimulus(img[k]);
  endtask

  task automatic loadSmallImage();
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    img[4] = 8'hA0; img[5] = 8'hB0; img[6] = 8'hC0; img[7] = 8'hD0;
  endtask

  initial begin
    // Reset: everything low while reset is held and after release.
    rst_async_n = 1'b0;
    #1;
    checkFlags("reset_flags_async", F_IDLE);
    checkOutput("reset_addr", 32'(imem_addr), 32'd0);
    checkOutput("reset_wdata", imem_wdata, 32'd0);
    applyReset();
    checkFlags("idle_flags", F_IDLE);

    // A byte offered while idle is ignored.
    rx_data = 8'h55; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checkFlags("idle_rx_ignored", F_IDLE);

    // Two-word image; checksum 0x11+0x22+0x33+0x44+0xA0+0xB0+0xC0+0xD0 = 0x8A.
    loadSmallImage();
    base = writeCount;
    pulseStart();
    checkFlags("t1_hdr_hi", F_RX);
    sendHeader(16'h0002);
    sendData(0, 3);
    checkFlags("t1_wr0_flags", F_WR);
    checkOutput("t1_wr0_addr", 32'(imem_addr), 32'd0);
    checkOutput("t1_wr0_data", imem_wdata, 32'h11223344);
    sendData(4, 7);
    checkFlags("t1_wr1_flags", F_WR);
    checkOutput("t1_wr1_addr", 32'(imem_addr), 32'd1);
    checkOutput("t1_wr1_data", imem_wdata, 32'hA0B0C0D0);
    tick();
    checkFlags("t1_csum_wait", F_RX);
    applyStimulus(8'h8A);
    checkFlags("t1_done", F_DONE);
    tick();
    checkOutput("t1_addr_hold", 32'(imem_addr), 32'd1);
    checkOutput("t1_data_hold", imem_wdata, 32'hA0B0C0D0);
    checkOutput("t1_write_count", 32'(writeCount - base), 32'd2);
    checkOutput("t1_log_data0", wrData[base % 64], 32'h11223344);

    // Bad checksum, then a full restart from the error state.
    applyReset();
    base = writeCount;
    pulseStart();
    sendHeader(16'h0002);
    sendData(0, 7);
    applyStimulus(8'h8B);
    checkFlags("t2_err", F_ERR);
    checkOutput("t2_write_count", 32'(writeCount - base), 32'd2);
    tick();
    checkFlags("t2_err_hold", F_ERR);
    base = writeCount;
    pulseStart();
    checkFlags("t2_restart", F_RX);
    sendHeader(16'h0002);
    sendData(0, 7);
    applyStimulus(8'h8A);
    checkFlags("t2_done", F_DONE);
    checkOutput("t2_restart_addr0", 32'(wrAddr[base % 64]), 32'd0);
    checkOutput("t2_restart_count", 32'(writeCount - base), 32'd2);

    // Word count larger than the memory is rejected on the second header byte.
    applyReset();
    base = writeCount;
    pulseStart();
    sendHeader(16'h0011);
    checkFlags("t3_too_big", F_ERR);
    tick();
    checkOutput("t3_no_writes", 32'(writeCount - base), 32'd0);

    // Word count equal to the memory size fills every address.
    applyReset();
    sumExp = 8'h00;
    for (int k = 0; k < 64; k++) begin
      img[k] = 8'(7 * k + 3);
      sumExp = sumExp + img[k];
    end
    base = writeCount;
    pulseStart();
    sendHeader(16'h0010);
    sendData(0, 63);
    applyStimulus(sumExp);
    checkFlags("tfull_done", F_DONE);
    checkOutput("tfull_count", 32'(writeCount - base), 32'd16);
    checkOutput("tfull_last_addr", 32'(wrAddr[(base + 15) % 64]), 32'd15);
    checkOutput("tfull_last_data", wrData[(base + 15) % 64], {img[60], img[61], img[62], img[63]});

    // Inactivity timeout: 99 idle cycles are tolerated, the 100th aborts.
    loadSmallImage();
    applyReset();
    pulseStart();
    sendHeader(16'h0002);
    sendData(0, 4);
    for (int k = 0; k < TIMEOUT_CYC - 1; k++) tick();
    checkFlags("t4_before_expire", F_RX);
    tick();
    checkFlags("t4_expired", F_ERR);

    // A byte arriving exactly on the expiring cycle wins.
    base = writeCount;
    pulseStart();
    sendHeader(16'h0002);
    sendData(0, 4);
    for (int k = 0; k < TIMEOUT_CYC - 1; k++) tick();
    applyStimulus(img[5]);
    checkFlags("t4_byte_wins", F_RX);
    sendData(6, 7);
    applyStimulus(8'h8A);
    checkFlags("t4_done", F_DONE);
    checkOutput("t4_last_addr", 32'(wrAddr[(base + 1) % 64]), 32'd1);

    // Empty image, and boot_start in DONE has no effect.
    applyReset();
    base = writeCount;
    pulseStart();
    sendHeader(16'h0000);
    checkFlags("t5_csum", F_RX);
    applyStimulus(8'h00);
    checkFlags("t5_done", F_DONE);
    pulseStart();
    tick();
    checkFlags("t5_start_ignored", F_DONE);
    checkOutput("t5_no_writes", 32'(writeCount - base), 32'd0);

    // Reset in the middle of the data phase, then a clean boot.
    pulseStart();
    applyReset();
    pulseStart();
    sendHeader(16'h0002);
    sendData(0, 5);
    rst_async_n = 1'b0;
    #1;
    checkFlags("t6_reset_flags", F_IDLE);
    checkOutput("t6_reset_wdata", imem_wdata, 32'd0);
    tick();
    rst_async_n = 1'b1;
    tick();
    tick();
    tick();
    base = writeCount;
    pulseStart();
    sendHeader(16'h0002);
    sendData(0, 7);
    applyStimulus(8'h8A);
    checkFlags("t6_done", F_DONE);
    checkOutput("t6_count", 32'(writeCount - base), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
